// File: rtl/loop_slot_arb.sv
// Periodic slot arbiter: a free-running period counter emits an ack slot pulse,
// and each slot grants one loop resource round-robin until release or hold timeout.
module loop_slot_arb #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned PERIOD   = 15,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             ack,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [CW-1:0]    CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [PW-1:0]    PTR_LAST  = PW'(N_REQ - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] GNT_ONE   = N_REQ'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_n;
  logic [HW-1:0]    hold;
  logic [HW-1:0]    hold_n;
  logic [N_REQ-1:0] gnt_n;
  logic             timeout_n;
  logic             slot;
  logic             owner_req;
  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;

  assign slot      = (cnt == CNT_LAST);
  assign owner_req = |(req & gnt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, round-robin winner search and grant bookkeeping
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    ptr_n     = ptr;
    hold_n    = hold;
    timeout_n = 1'b0;
    found     = 1'b0;
    win       = '0;
    idx       = '0;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state)
      IDLE: begin
        gnt_n = '0;
        if (slot && found) begin
          state_n = GRANT;
          gnt_n   = GNT_ONE << win;
          ptr_n   = (win == PTR_LAST) ? '0 : win + PW'(1);
          hold_n  = '0;
        end
      end
      GRANT: begin
        // Release takes priority over the hold limit
        if (!owner_req) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else if (hold == HOLD_LAST) begin
          state_n   = IDLE;
          gnt_n     = '0;
          timeout_n = 1'b1;
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // Period counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ack     <= 1'b0;
      gnt     <= '0;
      ptr     <= '0;
      hold    <= '0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      cnt     <= slot ? '0 : cnt + CW'(1);
      ack     <= slot;
      gnt     <= gnt_n;
      ptr     <= ptr_n;
      hold    <= hold_n;
      timeout <= timeout_n;
      busy    <= (state_n == GRANT);
    end
  end

endmodule

// File: tb/tb_loop_slot_arb.sv
// Bench for loop_slot_arb: default instance plus a long-hold instance so grants
// can span a slot; both are compared every cycle against a per-requester model.
module tb_loop_slot_arb;

  localparam int N    = 4;
  localparam int P    = 15;
  localparam int MH   = 8;
  localparam int LONG = 32;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt_s, gnt_l;
  logic       ack_s, ack_l, busy_s, busy_l, to_s, to_l;
  logic [6:0] obs_s, obs_l;

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 = default instance, 1 = long-hold instance
  int   m_t;
  logic m_ack;
  int   m_owner [2];
  int   m_len   [2];
  int   m_ptr   [2];
  logic m_to    [2];

  loop_slot_arb dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_s), .ack(ack_s), .busy(busy_s), .timeout(to_s)
  );

  loop_slot_arb #(.N_REQ(4), .PERIOD(15), .MAX_HOLD(LONG)) dut_l (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_l), .ack(ack_l), .busy(busy_l), .timeout(to_l)
  );

  assign obs_s = {gnt_s, ack_s, busy_s, to_s};
  assign obs_l = {gnt_l, ack_l, busy_l, to_l};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_vec(input int k);
    logic [3:0] g;
    g = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
    return {g, m_ack, (m_owner[k] >= 0), m_to[k]};
  endfunction

  // Advance the model by one rising edge, from the rules: slot every P edges,
  // round-robin pick, grant lasts until req drops or its length reaches the limit.
  task automatic model_edge(input logic rv, input logic [3:0] r);
    int mh;
    int c;
    if (rv) begin
      m_t = 0;
      m_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = -1; m_len[k] = 0; m_ptr[k] = 0; m_to[k] = 1'b0;
      end
    end else begin
      m_t++;
      m_ack = ((m_t % P) == 0);
      for (int k = 0; k < 2; k++) begin
        mh = (k == 0) ? MH : LONG;
        m_to[k] = 1'b0;
        if (m_owner[k] >= 0) begin
          if (((r >> m_owner[k]) & 4'b0001) == 4'b0000) begin
            m_owner[k] = -1;
          end else if (m_len[k] == mh) begin
            m_owner[k] = -1;
            m_to[k] = 1'b1;
          end else begin
            m_len[k]++;
          end
        end else if (m_ack && r != 4'b0000) begin
          for (int j = 0; j < N; j++) begin
            c = (m_ptr[k] + j) % N;
            if (m_owner[k] < 0 && ((r >> c) & 4'b0001) != 4'b0000) m_owner[k] = c;
          end
          m_ptr[k] = (m_owner[k] + 1) % N;
          m_len[k] = 1;
        end
      end
    end
  endtask

  task automatic tick(input logic rv, input logic [3:0] r);
    rst = rv;
    req = r;
    @(posedge clk);
    model_edge(rv, r);
    #1;
  endtask

  task automatic test_reset;
    tick(1'b1, 4'b0000);
    tick(1'b1, 4'b1111);
    checks++;
    if (obs_s !== 7'b0) begin
      errors++;
      $display("FAIL reset_state dut got %b expected %b", obs_s, 7'b0);
    end
    checks++;
    if (obs_l !== 7'b0) begin
      errors++;
      $display("FAIL reset_state dut_l got %b expected %b", obs_l, 7'b0);
    end
  endtask

  task automatic test_idle_ack;
    int acks = 0;
    int first = -1;
    tick(1'b1, 4'b0000);
    for (int e = 1; e <= 100 * P; e++) begin
      tick(1'b0, 4'b0000);
      checks++;
      if (obs_s !== exp_vec(0) || obs_l !== exp_vec(1)) begin
        errors++;
        $display("FAIL idle_cycle edge %0d got %b/%b expected %b/%b", e, obs_s, obs_l, exp_vec(0), exp_vec(1));
      end
      if (ack_s) begin
        acks++;
        if (first < 0) first = e;
      end
    end
    checks++;
    if (acks !== 100) begin
      errors++;
      $display("FAIL idle_ack_count got %0d expected 100", acks);
    end
    checks++;
    if (first !== P) begin
      errors++;
      $display("FAIL idle_first_ack got edge %0d expected %0d", first, P);
    end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int len = 0;
    logic [3:0] r;
    logic [3:0] prev = 4'b0000;
    tick(1'b1, 4'b0000);
    for (int e = 1; e <= 6 * P && n < 5; e++) begin
      r = 4'b1111;
      if (m_owner[0] >= 0 && m_len[0] == 2) r = r & ~(4'b0001 << m_owner[0]);
      tick(1'b0, r);
      checks++;
      if (obs_s !== exp_vec(0) || obs_l !== exp_vec(1)) begin
        errors++;
        $display("FAIL rr_cycle edge %0d got %b/%b expected %b/%b", e, obs_s, obs_l, exp_vec(0), exp_vec(1));
      end
      if (gnt_s != 4'b0000 && prev == 4'b0000) begin
        checks++;
        if (gnt_s !== (4'b0001 << order[n]) || ack_s !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant #%0d got gnt %b ack %b expected gnt %b ack 1", n, gnt_s, ack_s, 4'b0001 << order[n]);
        end
        len = 0;
      end
      if (gnt_s != 4'b0000) len++;
      if (gnt_s == 4'b0000 && prev != 4'b0000) begin
        checks++;
        if (len !== 2) begin
          errors++;
          $display("FAIL rr_len #%0d got %0d expected 2", n, len);
        end
        n++;
      end
      prev = gnt_s;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL rr_grant_total got %0d expected 5", n);
    end
  endtask

  task automatic test_timeout;
    int hi = 0;
    int tos = 0;
    int rises [$];
    logic [3:0] prev = 4'b0000;
    tick(1'b1, 4'b0000);
    for (int e = 1; e <= 40; e++) begin
      tick(1'b0, 4'b0100);
      checks++;
      if (obs_s !== exp_vec(0) || obs_l !== exp_vec(1)) begin
        errors++;
        $display("FAIL to_cycle edge %0d got %b/%b expected %b/%b", e, obs_s, obs_l, exp_vec(0), exp_vec(1));
      end
      if (gnt_s == 4'b0100) hi++;
      if (to_s) tos++;
      if (gnt_s != 4'b0000 && prev == 4'b0000) rises.push_back(e);
      if (e == 23) begin
        checks++;
        if (to_s !== 1'b1 || gnt_s !== 4'b0000) begin
          errors++;
          $display("FAIL to_pulse_edge23 got to %b gnt %b expected to 1 gnt 0000", to_s, gnt_s);
        end
      end
      prev = gnt_s;
    end
    checks++;
    if (hi !== 2 * MH || tos !== 2) begin
      errors++;
      $display("FAIL to_totals got gnt cycles %0d timeouts %0d expected %0d and 2", hi, tos, 2 * MH);
    end
    checks++;
    if (rises.size() !== 2 || rises[0] !== P || rises[1] !== 2 * P) begin
      errors++;
      $display("FAIL to_grant_times got %p expected 15 and 30", rises);
    end
  endtask

  task automatic test_hold_across_slot;
    logic [3:0] r;
    tick(1'b1, 4'b0000);
    for (int e = 1; e <= 46; e++) begin
      r = (e < 35) ? 4'b0010 : 4'b0000;
      if (e >= 20) r = r | 4'b1000;
      tick(1'b0, r);
      checks++;
      if (obs_s !== exp_vec(0) || obs_l !== exp_vec(1)) begin
        errors++;
        $display("FAIL hold_cycle edge %0d got %b/%b expected %b/%b", e, obs_s, obs_l, exp_vec(0), exp_vec(1));
      end
      if (e == 30) begin
        checks++;
        if (gnt_l !== 4'b0010 || ack_l !== 1'b1) begin
          errors++;
          $display("FAIL hold_slot got gnt %b ack %b expected gnt 0010 ack 1", gnt_l, ack_l);
        end
      end
      if (e == 35 || e == 45) begin
        checks++;
        if (gnt_l !== ((e == 35) ? 4'b0000 : 4'b1000)) begin
          errors++;
          $display("FAIL hold_after_release edge %0d got %b expected %b", e, gnt_l, (e == 35) ? 4'b0000 : 4'b1000);
        end
      end
    end
  endtask

  task automatic test_release_at_slot;
    logic [3:0] r;
    tick(1'b1, 4'b0000);
    for (int e = 1; e <= 46; e++) begin
      r = {1'b0, (e >= 20), 1'b0, (e < 30)};
      tick(1'b0, r);
      checks++;
      if (obs_s !== exp_vec(0) || obs_l !== exp_vec(1)) begin
        errors++;
        $display("FAIL relslot_cycle edge %0d got %b/%b expected %b/%b", e, obs_s, obs_l, exp_vec(0), exp_vec(1));
      end
      if (e == 30 || e == 40 || e == 45) begin
        checks++;
        if (gnt_l !== ((e == 45) ? 4'b0100 : 4'b0000)) begin
          errors++;
          $display("FAIL relslot_gnt edge %0d got %b expected %b", e, gnt_l, (e == 45) ? 4'b0100 : 4'b0000);
        end
      end
    end
  endtask

  task automatic test_reset_mid_grant;
    tick(1'b1, 4'b0000);
    for (int e = 1; e <= 17; e++) tick(1'b0, 4'b0001);
    tick(1'b1, 4'b0001);
    checks++;
    if (obs_s !== 7'b0 || obs_l !== 7'b0) begin
      errors++;
      $display("FAIL midrst_outputs got %b/%b expected 0000000", obs_s, obs_l);
    end
    for (int e = 1; e <= P; e++) begin
      tick(1'b0, 4'b0011);
      checks++;
      if (obs_s !== exp_vec(0) || obs_l !== exp_vec(1)) begin
        errors++;
        $display("FAIL midrst_cycle edge %0d got %b/%b expected %b/%b", e, obs_s, obs_l, exp_vec(0), exp_vec(1));
      end
    end
    checks++;
    if (ack_s !== 1'b1 || gnt_s !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_regrant got ack %b gnt %b expected ack 1 gnt 0001", ack_s, gnt_s);
    end
  endtask

  task automatic test_random;
    logic [3:0] r = 4'b0000;
    logic rv;
    tick(1'b1, 4'b0000);
    for (int e = 1; e <= 3000; e++) begin
      if ($urandom_range(0, 3) == 0) r = r ^ (4'b0001 << $urandom_range(0, 3));
      rv = ($urandom_range(0, 399) == 0);
      tick(rv, r);
      checks++;
      if (obs_s !== exp_vec(0) || obs_l !== exp_vec(1)) begin
        errors++;
        $display("FAIL rand_cycle %0d req %b got %b/%b expected %b/%b", e, r, obs_s, obs_l, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_idle_ack();
    test_round_robin();
    test_timeout();
    test_hold_across_slot();
    test_release_at_slot();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_slot_arb.md
# loop_slot_arb

Periodic slot arbiter sharing one loop resource among `N_REQ` requesters. Free-running period counter; emits a one-cycle `ack` slot pulse every `PERIOD` cycles. At each slot, grants the resource round-robin to one pending requester and holds the grant until release or hold timeout. Sits between the requesters and the loop datapath; its `ack` cadence matches the loop's every-`PERIOD`-cycle acknowledge.

## Interface
- `N_REQ`, 4, number of requesters (>=1)
- `PERIOD`, 15, slot period in cycles (>=2)
- `MAX_HOLD`, 8, maximum grant length in cycles (>=1)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N_REQ  per-requester request level; must stay high while using the grant
- `gnt`  out  N_REQ  one-hot (or zero) registered grant
- `ack`  out  1  registered one-cycle slot pulse
- `busy`  out  1  high while state is GRANT
- `timeout`  out  1  one-cycle pulse when a grant is revoked by hold limit

## Operation
- Period counter `cnt`, width `$clog2(PERIOD)`, counts 0..PERIOD-1 and wraps to 0; `slot = (cnt == PERIOD-1)`.
- `ack <= slot` every cycle, independent of arbitration state.
- Round-robin pointer `ptr` in 0..N_REQ-1; search order ptr, ptr+1, ..., wrapping mod N_REQ.
- FSM states:
  - IDLE: if `slot` and `|req` -> winner = first set `req` bit in search order; `gnt <= onehot(winner)`; `ptr <= (winner+1) mod N_REQ`; `hold <= 0`; go to GRANT. Otherwise stay, `gnt = 0`.
  - GRANT: if `req[owner] == 0` -> `gnt <= 0`, go to IDLE (release). Else if `hold == MAX_HOLD-1` -> `gnt <= 0`, `timeout <= 1`, go to IDLE. Else `hold <= hold+1`, `gnt` unchanged.
- Release and timeout in the same cycle: release wins; no `timeout` pulse.
- Slots occurring while in GRANT are not used for arbitration. `ack` still pulses. No queued grant.
- Slot in the same cycle as release or timeout: FSM is in GRANT on that edge, so there is no grant. The next grant comes at the following slot.
- `ptr` advances only on a grant. Requests with no grant are not remembered; `req` is sampled only at the slot edge.
- `busy = (state == GRANT)`. `gnt` is never multi-hot.
- Reset: `cnt = 0`, `ptr = 0`, state IDLE, `hold = 0`, `gnt = 0`, `ack = 0`, `busy = 0`, `timeout = 0`. Reset mid-grant drops `gnt` on the same edge and restarts the period from 0.

## Timing
- First rising edge with `rst = 0` is E1, with `cnt` going 0->1. `cnt == PERIOD-1` after E(PERIOD-1). First `ack` is high after edge E(PERIOD), for one cycle. Thereafter `ack` is high every `PERIOD` cycles.
- Grant latency: `gnt` is high in the same cycle as the `ack` pulse for that slot, one edge after `slot`.
- Release latency: `req[owner]` low sampled at edge N -> `gnt` low after edge N. With `req` dropped the cycle after grant, the grant lasts 1 cycle.
- Timeout: a grant held continuously lasts exactly `MAX_HOLD` cycles. `timeout` is high in the first cycle with `gnt = 0`.
- `busy` rises and falls on the same edges as `|gnt`.

## Test plan
- Reset, `req = 0`, run 100 periods (N_REQ=4, PERIOD=15) -> `ack` high exactly once every 15 cycles, first after edge E15. `gnt` stays 0 and `busy` stays 0 throughout.
- `req = 4'b1111`; each grantee drops `req` for 1 cycle after 2 cycles of grant -> grants go to 0,1,2,3,0 on consecutive slots. Each `gnt` is 2 cycles long and aligned with `ack`.
- `req = 4'b0100` held high (MAX_HOLD=8) -> `gnt = 4'b0100` for exactly 8 cycles, then `timeout` pulses once. Next grant is again to 2, at the following slot, 15 cycles after the previous grant.
- Requester 1 holds a grant across a slot while `req[3]` is high -> no grant change at that slot and `ack` still pulses. After release, `gnt = 4'b1000` at the next slot.
- Release coincident with slot (`req[0]` drops on the `cnt == 14` edge while `req[2] = 1`) -> `gnt` goes 0 and there is no grant that slot. `gnt = 4'b0100` after the next slot.
- Assert `rst` for one cycle mid-grant -> `gnt`, `busy`, `ack` and `timeout` are 0 after that edge. `ptr` is back to 0, and the next `ack` comes 15 cycles after reset deasserts.
